acc_quant_out: RTL and testbench

Downstream stage of the channel-parallel multiply/adder-tree accumulator. Captures each completed accumulation result and quantizes it back to the activation width. Quantization steps, in order: bias add, round-half-up right shift, signed saturation, optional ReLU. Results go into a small output FIFO drained by a valid/ready consumer (the next layer's writer). The accumulator cannot stall, so the block exposes a credit-style full_o and flags any dropped result.

---
 rtl/acc_pkg.sv | 40 ++++
 rtl/acc_quant_out_if.sv | 26 ++
 rtl/acc_quant_out_sync_fifo_fwft.sv | 54 +++++
 rtl/acc_quant_out.sv | 120 ++++++++++++
 tb/tb_acc_quant_out.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared widths and arithmetic helpers for the accumulator output quantizer.
package acc_pkg;

    localparam int unsigned ACC_WIDTH_DEF  = 40;
    localparam int unsigned BIAS_WIDTH_DEF = 32;
    localparam int unsigned DW_DEF         = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned SAT_CNT_W_DEF  = 16;
    localparam int unsigned SHIFT_W        = 5;
    localparam int unsigned MAX_W          = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic wide_t sat_max(input int unsigned w);
        wide_t one;
        one = wide_t'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic wide_t sat_min(input int unsigned w);
        return -sat_max(w) - wide_t'(1);
    endfunction

    function automatic logic sat_hit(input wide_t v, input int unsigned w);
        return (v > sat_max(w)) || (v < sat_min(w));
    endfunction

    function automatic wide_t sat_to(input wide_t v, input int unsigned w);
        if (v > sat_max(w)) return sat_max(w);
        if (v < sat_min(w)) return sat_min(w);
        return v;
    endfunction

    // Half-LSB of the shifted result; adding it before an arithmetic shift rounds half up.
    function automatic wide_t rnd_const(input logic [SHIFT_W-1:0] sh);
        if (sh == '0) return '0;
        return wide_t'(1) <<< (sh - SHIFT_W'(1));
    endfunction

endpackage

// File: rtl/acc_quant_out_if.sv
// Accumulator strobe input and quantized valid/ready output bundle.
interface acc_quant_out_if #(
    parameter int unsigned ACC_WIDTH  = acc_pkg::ACC_WIDTH_DEF,
    parameter int unsigned BIAS_WIDTH = acc_pkg::BIAS_WIDTH_DEF,
    parameter int unsigned DW         = acc_pkg::DW_DEF
);
    logic signed [ACC_WIDTH-1:0]  acc_i;
    logic                         acc_vld_i;
    logic signed [BIAS_WIDTH-1:0] bias_i;
    logic [4:0]                   shift_i;
    logic                         relu_en_i;
    logic signed [DW-1:0]         dout_o;
    logic                         dout_vld_o;
    logic                         dout_rdy_i;
    logic                         full_o;

    modport master (
        output acc_i, acc_vld_i, bias_i, shift_i, relu_en_i, dout_rdy_i,
        input  dout_o, dout_vld_o, full_o
    );

    modport slave (
        input  acc_i, acc_vld_i, bias_i, shift_i, relu_en_i, dout_rdy_i,
        output dout_o, dout_vld_o, full_o
    );
endinterface

// File: rtl/acc_quant_out_sync_fifo_fwft.sv
// Show-ahead synchronous FIFO with registered occupancy count.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Empty head reads as zero so nothing stale is visible after reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/acc_quant_out.sv
// Quantizes completed accumulations (bias, round, saturate, ReLU) into a
// credit-managed output FIFO.
module acc_quant_out
    import acc_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned BIAS_WIDTH = BIAS_WIDTH_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned SAT_CNT_W  = SAT_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    acc_quant_out_if.slave       s_bus,
    output logic                 ovf_o,
    output logic [SAT_CNT_W-1:0] sat_cnt_o
);
    localparam int unsigned S1_W  = ACC_WIDTH + 1;
    localparam int unsigned S2_W  = ACC_WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 2;

    logic                   w_full;
    logic                   w_accept;
    logic signed [S1_W-1:0] w_s1_sum;
    logic signed [S2_W-1:0] w_s2_sum;
    logic signed [S2_W-1:0] w_s2_shr;
    wide_t                  w_s3_wide;
    logic                   w_s3_sat;
    logic [DW-1:0]          w_s3_q;
    logic [DW-1:0]          w_fifo_rdata;
    logic [CNT_W-1:0]       w_fifo_count;
    logic                   w_fifo_empty;
    logic                   w_pop;
    logic [OCC_W-1:0]       w_occ;

    logic                   r_s1_vld;
    logic signed [S1_W-1:0] r_s1_sum;
    logic [SHIFT_W-1:0]     r_s1_shift;
    logic                   r_s1_relu;
    logic                   r_s2_vld;
    logic signed [S2_W-1:0] r_s2_val;
    logic                   r_s2_relu;
    logic                   r_s3_vld;
    logic [DW-1:0]          r_s3_data;
    logic                   r_ovf;
    logic [SAT_CNT_W-1:0]   r_sat_cnt;

    // Every in-flight result already owns a FIFO slot; a same-cycle pop frees credit one cycle later.
    assign w_occ    = OCC_W'(w_fifo_count) + OCC_W'(r_s1_vld) + OCC_W'(r_s2_vld)
                    + OCC_W'(r_s3_vld);
    assign w_full   = (w_occ >= OCC_W'(FIFO_DEPTH));
    assign w_accept = s_bus.acc_vld_i & ~w_full;

    assign w_s1_sum  = S1_W'(s_bus.acc_i) + S1_W'(s_bus.bias_i);
    assign w_s2_sum  = S2_W'(r_s1_sum) + S2_W'(rnd_const(r_s1_shift));
    assign w_s2_shr  = w_s2_sum >>> r_s1_shift;
    assign w_s3_wide = MAX_W'(r_s2_val);
    assign w_s3_sat  = sat_hit(w_s3_wide, DW);

    always_comb begin
        w_s3_q = DW'(sat_to(w_s3_wide, DW));
        if (r_s2_relu && w_s3_q[DW-1]) w_s3_q = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_shift <= '0;
            r_s1_relu  <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_val   <= '0;
            r_s2_relu  <= 1'b0;
            r_s3_vld   <= 1'b0;
            r_s3_data  <= '0;
            r_ovf      <= 1'b0;
            r_sat_cnt  <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_sum   <= w_s1_sum;
                r_s1_shift <= s_bus.shift_i;
                r_s1_relu  <= s_bus.relu_en_i;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_val  <= w_s2_shr;
                r_s2_relu <= r_s1_relu;
            end
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) r_s3_data <= w_s3_q;
            if (s_bus.acc_vld_i && w_full) r_ovf <= 1'b1;
            if (r_s2_vld && w_s3_sat && (r_sat_cnt != '1)) begin
                r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s3_vld),
        .i_wdata (r_s3_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign w_pop            = ~w_fifo_empty & s_bus.dout_rdy_i;
    assign s_bus.dout_o     = w_fifo_rdata;
    assign s_bus.dout_vld_o = ~w_fifo_empty;
    assign s_bus.full_o     = w_full;
    assign ovf_o            = r_ovf;
    assign sat_cnt_o        = r_sat_cnt;
endmodule

// File: tb/tb_acc_quant_out.sv
// Self-checking bench for acc_quant_out: vector table plus scoreboard-checked sequences.
module tb_acc_quant_out;

    logic        clk;
    logic        rst;
    logic        ovf;
    logic [15:0] sat_cnt;

    int n_chk;
    int n_err;
    int exp_q[$];

    acc_quant_out_if #(.ACC_WIDTH(40), .BIAS_WIDTH(32), .DW(8)) bus ();

    acc_quant_out #(
        .ACC_WIDTH  (40),
        .BIAS_WIDTH (32),
        .DW         (8),
        .FIFO_DEPTH (4),
        .SAT_CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_bus     (bus),
        .ovf_o     (ovf),
        .sat_cnt_o (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        longint bias;
        int     shift;
        bit     relu;
        int     exp;
        bit     sat;
    } vec_t;

    function automatic void chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Credit-respecting producer: waits (bounded) for full_o low, then strobes one cycle.
    task automatic send(input longint acc, input longint bias, input int shift, input bit relu,
                        input int exp);
        int waited;
        waited = 0;
        while (bus.full_o && waited < 100) begin
            tick();
            waited++;
        end
        if (bus.full_o) chk("credit_wait_timeout", 1, 0);
        bus.acc_i     = 40'(acc);
        bus.bias_i    = 32'(bias);
        bus.shift_i   = 5'(shift);
        bus.relu_en_i = relu;
        bus.acc_vld_i = 1'b1;
        exp_q.push_back(exp);
        tick();
        bus.acc_vld_i = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            tick();
            waited++;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"}, longint'(bus.dout_o), 0);
        chk({tag, "_dout_vld"}, bus.dout_vld_o, 0);
        chk({tag, "_full"}, bus.full_o, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_sat_cnt"}, sat_cnt, 0);
    endtask

    // Scoreboard: every accepted beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.dout_vld_o && bus.dout_rdy_i) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL dout_unexpected: got %0d, required no beat", bus.dout_o);
            end else begin
                chk("dout_beat", longint'(bus.dout_o), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        int   exp_sat;
        int   stale;

        n_chk = 0;
        n_err = 0;
        tbl[0]  = '{1000, 8, 4, 1'b0, 63, 1'b0};
        tbl[1]  = '{24, 0, 4, 1'b0, 2, 1'b0};
        tbl[2]  = '{-24, 0, 4, 1'b0, -1, 1'b0};
        tbl[3]  = '{23, 0, 4, 1'b0, 1, 1'b0};
        tbl[4]  = '{-5, 0, 0, 1'b0, -5, 1'b0};
        tbl[5]  = '{100000, 0, 0, 1'b0, 127, 1'b1};
        tbl[6]  = '{-100000, 0, 0, 1'b0, -128, 1'b1};
        tbl[7]  = '{-100000, 0, 0, 1'b1, 0, 1'b1};
        tbl[8]  = '{-40, 0, 4, 1'b1, 0, 1'b0};
        tbl[9]  = '{127, 0, 0, 1'b0, 127, 1'b0};
        tbl[10] = '{128, 0, 0, 1'b0, 127, 1'b1};
        tbl[11] = '{-128, 0, 0, 1'b0, -128, 1'b0};
        tbl[12] = '{-129, 0, 0, 1'b0, -128, 1'b1};
        tbl[13] = '{64'sd34359738368, 0, 31, 1'b0, 16, 1'b0};
        tbl[14] = '{-3, 0, 1, 1'b0, -1, 1'b0};
        tbl[15] = '{0, -64'sd2147483648, 24, 1'b0, -128, 1'b0};

        rst = 1'b1;
        bus.acc_i = '0;
        bus.acc_vld_i = 1'b0;
        bus.bias_i = '0;
        bus.shift_i = '0;
        bus.relu_en_i = 1'b0;
        bus.dout_rdy_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_state("reset");

        // Basic beat with exact latency: visible on the third edge after the accepting one.
        send(1000, 8, 4, 1'b0, 63);
        chk("lat_e0_vld", bus.dout_vld_o, 0);
        tick();
        chk("lat_e1_vld", bus.dout_vld_o, 0);
        tick();
        chk("lat_e2_vld", bus.dout_vld_o, 0);
        tick();
        chk("lat_e3_vld", bus.dout_vld_o, 1);
        chk("lat_e3_dout", longint'(bus.dout_o), 63);
        drain();

        exp_sat = 0;
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].acc, tbl[i].bias, tbl[i].shift, tbl[i].relu, tbl[i].exp);
            exp_sat += int'(tbl[i].sat);
        end
        drain();
        chk("table_sat_cnt", sat_cnt, exp_sat);
        chk("table_ovf", ovf, 0);

        // Backpressure: six raw strobes with the consumer stalled.
        bus.dout_rdy_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_full_before_%0d", k), bus.full_o, (k >= 4) ? 1 : 0);
            bus.acc_i     = 40'((10 + k) * 16);
            bus.bias_i    = '0;
            bus.shift_i   = 5'd4;
            bus.relu_en_i = 1'b0;
            bus.acc_vld_i = 1'b1;
            if (k < 4) exp_q.push_back(10 + k);
            tick();
        end
        bus.acc_vld_i = 1'b0;
        chk("bp_ovf", ovf, 1);
        repeat (4) tick();
        chk("bp_hold_vld", bus.dout_vld_o, 1);
        chk("bp_hold_dout", longint'(bus.dout_o), 10);
        chk("bp_hold_full", bus.full_o, 1);
        bus.dout_rdy_i = 1'b1;
        drain();
        repeat (5) tick();
        chk("bp_after_vld", bus.dout_vld_o, 0);
        chk("bp_after_full", bus.full_o, 0);
        chk("bp_ovf_sticky", ovf, 1);

        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check_reset_state("reset2");

        // Steady stream with two entries parked in the FIFO.
        bus.dout_rdy_i = 1'b0;
        send(20 * 16, 0, 4, 1'b0, 20);
        send(21 * 16, 0, 4, 1'b0, 21);
        repeat (4) tick();
        chk("pp_parked_vld", bus.dout_vld_o, 1);
        bus.dout_rdy_i = 1'b1;
        for (int k = 0; k < 16; k++) send(longint'((30 + k) * 16), 0, 4, 1'b0, 30 + k);
        drain();
        chk("pp_ovf", ovf, 0);

        // Reset with three results buffered and one in flight (plus one dropped strobe).
        bus.dout_rdy_i = 1'b0;
        send(5 * 16, 0, 4, 1'b0, 5);
        send(6 * 16, 0, 4, 1'b0, 6);
        send(7 * 16, 0, 4, 1'b0, 7);
        repeat (4) tick();
        send(100000, 0, 0, 1'b0, 127);
        bus.acc_vld_i = 1'b1;
        tick();
        bus.acc_vld_i = 1'b0;
        tick();
        chk("mid_ovf_pre", ovf, 1);
        chk("mid_sat_pre", sat_cnt, 1);
        chk("mid_vld_pre", bus.dout_vld_o, 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_reset_state("mid_reset");
        rst = 1'b0;
        bus.dout_rdy_i = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.dout_vld_o) stale++;
        end
        chk("mid_stale_beats", stale, 0);
        chk("mid_full_after", bus.full_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
